// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty meter and its input-capture helpers.
package pwm_pkg;

    localparam int unsigned CW_DEFAULT = 27;
    localparam int unsigned NUM_FREQ   = 9;

    // Nominal periods in CLKin cycles; the array index is the generator's frequency code
    localparam int unsigned PERIOD_TAB [0:8] = '{20001, 3333, 1999, 1333, 999, 799, 667, 569, 499};

    localparam logic [3:0] FREQ_UNKNOWN = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Map a measured period to the frequency code whose nominal period is within +/-tol
    function automatic logic [3:0] freq_class(input logic [31:0] cyc, input int unsigned tol);
        logic [3:0] code;
        code = FREQ_UNKNOWN;
        for (int unsigned i = 0; i < NUM_FREQ; i++) begin
            if (cyc >= PERIOD_TAB[i]) begin
                if ((cyc - PERIOD_TAB[i]) <= tol) code = 4'(i);
            end else begin
                if ((PERIOD_TAB[i] - cyc) <= tol) code = 4'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Measurement result bundle published by pwm_duty_meter.
interface pwm_duty_meter_if
    import pwm_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT
);
    logic [CW-1:0] Period;
    logic [CW-1:0] High;
    logic [3:0]    FreqCode;
    logic          MeasValid;
    logic          NoSignal;
    logic          StuckLevel;

    modport master (output Period, High, FreqCode, MeasValid, NoSignal, StuckLevel);
    modport slave  (input  Period, High, FreqCode, MeasValid, NoSignal, StuckLevel);
endinterface

// File: rtl/pwm_edge_sync.sv
// Input capture front end: 2-FF synchronizer, optional deglitch filter, edge detect.
// Optional feature: define PWM_DEGLITCH_EN to accept a level change only after it
// has been seen for 3 consecutive cycles (adds 2 cycles to both edges).
module pwm_edge_sync (
    input  logic CLKin,
    input  logic rst,
    input  logic din,
    output logic level_c,
    output logic rise_c,
    output logic fall_c
);
    logic sync1;
    logic sync2;
    logic prev;
    logic s_c;

    // Two-stage synchronizer for the asynchronous input
    always_ff @(posedge CLKin) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

`ifdef PWM_DEGLITCH_EN
    logic hist1;
    logic hist2;

    // History of the synchronized level for the stability window
    always_ff @(posedge CLKin) begin
        if (rst) begin
            hist1 <= 1'b0;
            hist2 <= 1'b0;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
        end
    end

    // Take the new level only once three consecutive samples agree; otherwise hold
    assign s_c = ((sync2 == hist1) && (hist1 == hist2)) ? sync2 : prev;
`else
    assign s_c = sync2;
`endif

    // Previous accepted level for edge detection
    always_ff @(posedge CLKin) begin
        if (rst) prev <= 1'b0;
        else     prev <= s_c;
    end

    assign level_c = s_c;
    assign rise_c  = s_c & ~prev;
    assign fall_c  = ~s_c & prev;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an incoming PWM signal in CLKin cycles,
// classifies the period into a frequency code and flags a missing/stuck input.
// Optional feature: PWM_DEGLITCH_EN (input deglitch filter in pwm_edge_sync).
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int unsigned CW      = CW_DEFAULT,
    parameter int unsigned TOL     = 2,
    parameter int unsigned TIMEOUT = 65536
) (
    input  logic CLKin,
    input  logic rst,
    input  logic PWMin,
    pwm_duty_meter_if.master meas
);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic level_c;
    logic rise_c;
    logic fall_c;

    state_t        state_q,    state_nxt;
    logic [CW-1:0] cnt_q,      cnt_nxt;
    logic [CW-1:0] high_lat_q, high_lat_nxt;
    logic [CW-1:0] period_q,   period_nxt;
    logic [CW-1:0] high_q,     high_nxt;
    logic [3:0]    code_q,     code_nxt;
    logic          valid_q,    valid_nxt;
    logic          nosig_q,    nosig_nxt;
    logic          stuck_q,    stuck_nxt;
    logic          timeout_c;

    pwm_edge_sync u_edge_sync (
        .CLKin   (CLKin),
        .rst     (rst),
        .din     (PWMin),
        .level_c (level_c),
        .rise_c  (rise_c),
        .fall_c  (fall_c)
    );

    // A fall in IDLE/HIGH can push cnt past the timeout point, so compare with >=
    assign timeout_c = (cnt_q >= TO_LAST) && !(rise_c || fall_c);

    // State and measurement registers
    always_ff @(posedge CLKin) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_lat_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            code_q     <= FREQ_UNKNOWN;
            valid_q    <= 1'b0;
            nosig_q    <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            high_lat_q <= high_lat_nxt;
            period_q   <= period_nxt;
            high_q     <= high_nxt;
            code_q     <= code_nxt;
            valid_q    <= valid_nxt;
            nosig_q    <= nosig_nxt;
            stuck_q    <= stuck_nxt;
        end
    end

    // Next-state, counter and publish logic
    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        high_lat_nxt = high_lat_q;
        period_nxt   = period_q;
        high_nxt     = high_q;
        code_nxt     = code_q;
        valid_nxt    = 1'b0;
        nosig_nxt    = nosig_q;
        stuck_nxt    = stuck_q;

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    cnt_nxt   = CW'(1);
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (fall_c) begin
                    high_lat_nxt = cnt_q;
                    state_nxt    = LOW;
                end
            end
            LOW: begin
                if (rise_c) begin
                    period_nxt = cnt_q;
                    high_nxt   = high_lat_q;
                    code_nxt   = freq_class(32'(cnt_q), TOL);
                    valid_nxt  = 1'b1;
                    nosig_nxt  = 1'b0;
                    cnt_nxt    = CW'(1);
                    state_nxt  = HIGH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (timeout_c) begin
            nosig_nxt = 1'b1;
            stuck_nxt = level_c;
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    assign meas.Period     = period_q;
    assign meas.High       = high_q;
    assign meas.FreqCode   = code_q;
    assign meas.MeasValid  = valid_q;
    assign meas.NoSignal   = nosig_q;
    assign meas.StuckLevel = stuck_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter: directed PWM waveforms, expected
// measurements queued at each closing rising edge and checked by a monitor.
module tb_pwm_duty_meter;

    localparam int unsigned CW = 27;
    // Shortened timeout (still above the longest table period) keeps the run short
    localparam int unsigned TO = 20100;

    typedef struct {
        int unsigned period;
        int unsigned high;
        logic [3:0]  code;
    } exp_t;

    logic CLKin;
    logic rst;
    logic PWMin;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    exp_t last_m;
    exp_t got_e;
    bit   armed;

    pwm_duty_meter_if #(.CW(CW)) meas ();

    pwm_duty_meter #(
        .CW      (CW),
        .TOL     (2),
        .TIMEOUT (TO)
    ) u_dut (
        .CLKin (CLKin),
        .rst   (rst),
        .PWMin (PWMin),
        .meas  (meas)
    );

    initial CLKin = 1'b0;
    always #5 CLKin = ~CLKin;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Monitor: every MeasValid pulse must match the oldest queued expectation
    always @(negedge CLKin) begin
        if (!rst && meas.MeasValid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_meas Period=%0d High=%0d FreqCode=%0h (none expected)",
                         meas.Period, meas.High, meas.FreqCode);
            end else begin
                got_e = exp_q.pop_front();
                if (32'(meas.Period) != got_e.period || 32'(meas.High) != got_e.high ||
                    meas.FreqCode !== got_e.code || meas.NoSignal !== 1'b0) begin
                    errors++;
                    $display("FAIL meas actual P=%0d H=%0d code=%0h nosig=%0b expected P=%0d H=%0d code=%0h nosig=0",
                             meas.Period, meas.High, meas.FreqCode, meas.NoSignal,
                             got_e.period, got_e.high, got_e.code);
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge CLKin);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_period"}, 32'(meas.Period), 32'd0);
        chk({tag, "_high"},   32'(meas.High), 32'd0);
        chk({tag, "_code"},   32'(meas.FreqCode), 32'hF);
        chk({tag, "_valid"},  32'(meas.MeasValid), 32'd0);
        chk({tag, "_nosig"},  32'(meas.NoSignal), 32'd0);
        chk({tag, "_stuck"},  32'(meas.StuckLevel), 32'd0);
    endtask

    // Rising edge that closes the previous period (if one was in progress)
    task automatic rise_edge();
        PWMin = 1'b1;
        if (armed) exp_q.push_back(last_m);
    endtask

    task automatic pwm(input int p, input int h, input int n, input logic [3:0] code);
        for (int k = 0; k < n; k++) begin
            rise_edge();
            hold(h);
            PWMin = 1'b0;
            hold(p - h);
            armed         = 1'b1;
            last_m.period = p;
            last_m.high   = h;
            last_m.code   = code;
        end
    endtask

    initial begin
        rst   = 1'b1;
        PWMin = 1'b0;
        armed = 1'b0;
        hold(3);
        chk_reset("reset");
        rst = 1'b0;
        hold(5);

        pwm(3333, 500, 3, 4'd1);
        pwm(20001, 1000, 1, 4'd0);
        pwm(1001, 500, 2, 4'd4);
        pwm(1010, 500, 2, 4'hF);

        // Close the last period, then hold low until the timeout
        rise_edge();
        armed = 1'b0;
        hold(10);
        PWMin = 1'b0;
        hold(20070);
        chk("nosig_before_low_to", 32'(meas.NoSignal), 32'd0);
        hold(40);
        chk("nosig_low_to", 32'(meas.NoSignal), 32'd1);
        chk("stuck_low", 32'(meas.StuckLevel), 32'd0);

        // Held high: one rising edge, then no activity
        PWMin = 1'b1;
        hold(20080);
        chk("stuck_before_high_to", 32'(meas.StuckLevel), 32'd0);
        hold(40);
        chk("nosig_high_to", 32'(meas.NoSignal), 32'd1);
        chk("stuck_high", 32'(meas.StuckLevel), 32'd1);

        // Recovery with period 499; NoSignal holds until the first measurement
        PWMin = 1'b0;
        hold(20);
        pwm(499, 250, 1, 4'd8);
        chk("nosig_held", 32'(meas.NoSignal), 32'd1);
        pwm(499, 250, 3, 4'd8);

        // Reset in the middle of a high phase
        rise_edge();
        hold(100);
        rst   = 1'b1;
        PWMin = 1'b0;
        armed = 1'b0;
        hold(1);
        chk_reset("midrst");
        rst = 1'b0;
        hold(50);

        // Period 799 with a 2-cycle glitch inside one low phase
        pwm(799, 400, 2, 4'd5);
        rise_edge();
        hold(400);
        PWMin = 1'b0;
        hold(200);
`ifdef PWM_DEGLITCH_EN
        PWMin = 1'b1;
        hold(2);
        PWMin = 1'b0;
        hold(197);
        last_m.period = 799;
        last_m.high   = 400;
        last_m.code   = 4'd5;
`else
        last_m.period = 600;
        last_m.high   = 400;
        last_m.code   = 4'hF;
        rise_edge();
        hold(2);
        PWMin = 1'b0;
        hold(197);
        last_m.period = 199;
        last_m.high   = 2;
        last_m.code   = 4'hF;
`endif
        rise_edge();
        hold(10);
        PWMin = 1'b0;
        hold(30);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
